word_adder_ctrl: RTL and testbench

Sequencer and two-port arbiter in front of word_adder.
- Accepts popcount jobs from two requesters over valid/ready and grants them round-robin.
- Drives word_adder's func/inWord command sequence (write, enable, add) and waits out the adder's fixed 8-cycle run.
- Returns the per-job increment of word_sum, which is the popcount of inWord[7:0], on a valid/ready response port.

---
 rtl/word_adder_ctrl_pkg.sv | 43 ++++
 rtl/word_adder_ctrl_arb.sv | 41 ++++
 rtl/word_adder_ctrl.sv | 157 +++++++++++++++
 tb/tb_word_adder_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/word_adder_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// word_adder_ctrl_pkg
// Shared definitions for the word_adder sequencer/arbiter:
//   - word_adder func encodings
//   - controller FSM state type
//   - default widths / run length of the adder
//   - helper mapping a controller state to the func it drives
// ----------------------------------------------------------------------------
package word_adder_ctrl_pkg;

    // Default job/data width and adder accumulate run length.
    localparam int W_DEF          = 9;
    localparam int RUN_CYCLES_DEF = 8;

    // word_adder func encodings.
    localparam logic [1:0] FUNC_IDLE   = 2'd0;
    localparam logic [1:0] FUNC_WRITE  = 2'd1;
    localparam logic [1:0] FUNC_ENABLE = 2'd2;
    localparam logic [1:0] FUNC_ADD    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_ENABLE = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESP   = 3'd5
    } ctrl_state_t;

    // Only the three command states talk to the adder; everything else is idle.
    function automatic logic [1:0] state_func(input ctrl_state_t s);
        logic [1:0] f;
        f = FUNC_IDLE;
        case (s)
            ST_WRITE:  f = FUNC_WRITE;
            ST_ENABLE: f = FUNC_ENABLE;
            ST_START:  f = FUNC_ADD;
            default:   f = FUNC_IDLE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/word_adder_ctrl_arb.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter.
//   clk, rst   : clock, asynchronous active-low reset
//   req[1:0]   : request vector (bit i = requester i valid)
//   accept     : current grant was taken; rotate priority
//   gnt[1:0]   : one-hot grant (all zero when no request)
// Priority state is the last granted requester; it resets to 1 so that
// requester 0 wins the first contested cycle.
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= gnt[1];
        end
    end

    // A lone request always wins; on contention the requester that did not
    // win last time goes next, so a held request is never starved.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/word_adder_ctrl.sv
// ----------------------------------------------------------------------------
// word_adder_ctrl
// Sequencer and two-port arbiter in front of word_adder. Accepts popcount
// jobs from two requesters, drives the adder command sequence
// (write, enable-once, add), waits out the adder run and returns the
// increment of word_sum (= popcount of word[7:0]) on a response port.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req0_valid/word/ready      requester 0 job handshake
//   req1_valid/word/ready      requester 1 job handshake
//   rsp_valid/data/id/ready    response handshake (id = owning requester)
//   adder_func                 word_adder func (0 idle,1 write,2 enable,3 add)
//   adder_inWord               word_adder inWord
//   adder_result               word_adder word_sum
// ----------------------------------------------------------------------------
module word_adder_ctrl
    import word_adder_ctrl_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_word,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_word,
    output logic         req1_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         rsp_id,
    input  logic         rsp_ready,
    output logic [1:0]   adder_func,
    output logic [W-1:0] adder_inWord,
    input  logic [W-1:0] adder_result
);

    localparam int CNT_W = $clog2(RUN_CYCLES + 1);

    ctrl_state_t    state, state_nxt;
    logic           enabled_q;
    logic [W-1:0]   word_q;
    logic           id_q;
    logic [W-1:0]   base_q;
    logic [W-1:0]   rsp_q;
    logic [CNT_W-1:0] wait_cnt;

    logic [1:0]     gnt;
    logic           in_idle;
    logic           accept;
    logic           wait_done;

    // ------------------------------------------------------------------
    // Arbitration / request handshake
    // ------------------------------------------------------------------
    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    // Readies are combinational and only offered in IDLE. Gating with rst
    // keeps them low while reset is held even if requesters are valid.
    assign in_idle    = (state == ST_IDLE) && rst;
    assign req0_ready = in_idle && gnt[0];
    assign req1_ready = in_idle && gnt[1];
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign wait_done  = (wait_cnt == CNT_W'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_WRITE;
            // The adder only needs enabling once per reset.
            ST_WRITE:  state_nxt = enabled_q ? ST_START : ST_ENABLE;
            ST_ENABLE: state_nxt = ST_START;
            ST_START:  state_nxt = ST_WAIT;
            ST_WAIT:   if (wait_done) state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        adder_func   = state_func(state);
        adder_inWord = '0;
        rsp_valid    = 1'b0;
        rsp_id       = 1'b0;
        rsp_data     = '0;
        if (state == ST_WRITE) begin
            adder_inWord = word_q;
        end
        if (state == ST_RESP) begin
            rsp_valid = 1'b1;
            rsp_id    = id_q;
            rsp_data  = rsp_q;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q    <= '0;
            id_q      <= 1'b0;
            enabled_q <= 1'b0;
            base_q    <= '0;
            wait_cnt  <= '0;
            rsp_q     <= '0;
        end else begin
            if (state == ST_IDLE && accept) begin
                word_q <= gnt[1] ? req1_word : req0_word;
                id_q   <= gnt[1];
            end
            if (state == ST_ENABLE) begin
                enabled_q <= 1'b1;
            end
            // In START the adder counter is still zero, so word_sum is the
            // settled total of all earlier jobs: a safe base for the delta.
            if (state == ST_START) begin
                base_q   <= adder_result;
                wait_cnt <= CNT_W'(RUN_CYCLES);
            end
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
                // Modular difference stays correct when word_sum wraps.
                if (wait_done) begin
                    rsp_q <= adder_result - base_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_word_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_word_adder_ctrl
// Bench for word_adder_ctrl. Contains a behavioural word_adder (write latches
// inWord, enable arms it, add sums inWord[7:0] one bit per cycle starting on
// the add edge, 8 bits total) and a job-level reference model: expected
// result is popcount(word[7:0]), expected grant follows round-robin, expected
// latency is 12 cycles for the first job after reset and 11 afterwards.
// ----------------------------------------------------------------------------
module tb_word_adder_ctrl;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_word, req1_word;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_id, rsp_ready;
    logic [W-1:0] rsp_data;
    logic [1:0]   adder_func;
    logic [W-1:0] adder_inWord, adder_result;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic m_last;   // last granted requester
    logic m_en;     // adder already enabled since reset

    always #5 clk = ~clk;

    word_adder_ctrl #(.W(W), .RUN_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_word    (req0_word),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_word    (req1_word),
        .req1_ready   (req1_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_ready    (rsp_ready),
        .adder_func   (adder_func),
        .adder_inWord (adder_inWord),
        .adder_result (adder_result)
    );

    // Behavioural word_adder, reset together with the controller.
    logic [W-1:0] a_word, a_sum;
    logic [7:0]   a_sh;
    logic         a_en;
    int           a_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_word <= '0; a_sum <= '0; a_sh <= '0; a_en <= 1'b0; a_cnt <= 0;
        end else begin
            case (adder_func)
                2'd1: a_word <= adder_inWord;
                2'd2: a_en <= 1'b1;
                2'd3: if (a_en) begin
                    a_sum <= a_sum + W'(a_word[0]);
                    a_sh  <= {1'b0, a_word[7:1]};
                    a_cnt <= 7;
                end
                default: if (a_cnt > 0) begin
                    a_sum <= a_sum + W'(a_sh[0]);
                    a_sh  <= a_sh >> 1;
                    a_cnt <= a_cnt - 1;
                end
            endcase
        end
    end
    assign adder_result = a_sum;

    function automatic int pc8(input logic [W-1:0] w);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(w[i]);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One job, entered and left at a negedge while the DUT is in IDLE.
    // keep: leave requester valids asserted after acceptance.
    // hold: cycles rsp_ready stays low once the response appears.
    task automatic do_job(input logic v0, input logic [W-1:0] w0,
                          input logic v1, input logic [W-1:0] w1,
                          input int hold, input logic keep);
        logic         g;
        logic [W-1:0] word;
        int           lat, exp_lat, ef;
        logic [W-1:0] d0;
        logic         i0;
        g    = (v0 && v1) ? ~m_last : ~v0;
        word = g ? w1 : w0;
        req0_valid = v0; req0_word = w0;
        req1_valid = v1; req1_word = w1;
        rsp_ready  = (hold == 0);
        #1;
        chk("grant_rdy", 32'({req1_ready, req0_ready}), g ? 32'd2 : 32'd1);
        @(posedge clk);
        m_last  = g;
        exp_lat = m_en ? 11 : 12;
        lat     = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1 && !keep) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #1;
            if (rsp_valid) begin
                lat = n;
                break;
            end
            if (m_en) ef = (n == 1) ? 1 : (n == 2) ? 3 : 0;
            else      ef = (n <= 3) ? n : 0;
            chk("func_seq", 32'(adder_func), 32'(ef));
            chk("busy_rdy", 32'({req1_ready, req0_ready}), 32'd0);
            if (n == 1) chk("inword", 32'(adder_inWord), 32'(word));
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        m_en = 1'b1;
        chk("rsp_data", 32'(rsp_data), 32'(pc8(word)));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        d0 = rsp_data; i0 = rsp_id;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'({i0, d0}), 32'({rsp_id, rsp_data}) ^ 32'(0));
            chk("hold_func", 32'(adder_func), 32'd0);
            chk("hold_rdy", 32'({req1_ready, req0_ready}), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b1; req0_word = 9'h0FF;
        req1_valid = 1'b1; req1_word = 9'h155;
        rsp_ready  = 1'b1;
        m_last = 1'b1; m_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outs", 32'({req0_ready, req1_ready, rsp_valid, rsp_id, adder_func}), 32'd0);
        chk("rst_data", 32'({rsp_data, adder_inWord}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // directed jobs
        do_job(1'b1, 9'h0FF, 1'b0, 9'h000, 0, 1'b0);   // first job: ENABLE, 8
        do_job(1'b0, 9'h000, 1'b1, 9'h155, 0, 1'b0);   // no ENABLE, 4
        do_job(1'b1, 9'h100, 1'b0, 9'h000, 0, 1'b0);   // bit 8 ignored, 0
        for (int j = 0; j < 4; j++)                    // both held valid
            do_job(1'b1, 9'h0F0, 1'b1, 9'h003, 0, 1'b1);
        do_job(1'b1, 9'h0AA, 1'b1, 9'h1C1, 5, 1'b1);   // backpressure
        do_job(1'b1, 9'h0AA, 1'b1, 9'h1C1, 0, 1'b0);

        // word_sum wraps past 511
        for (int j = 0; j < 65; j++)
            do_job(1'b1, 9'h0FF, 1'b0, 9'h000, 0, 1'b0);

        // randomized jobs
        for (int j = 0; j < 20; j++) begin
            logic v0, v1;
            v0 = 1'($urandom % 2);
            v1 = v0 ? 1'($urandom % 2) : 1'b1;
            do_job(v0, 9'($urandom), v1, 9'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        // reset during WAIT
        req0_valid = 1'b1; req0_word = 9'h0F3; req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_outs", 32'({req0_ready, req1_ready, rsp_valid, rsp_id, adder_func}), 32'd0);
        chk("midrst_data", 32'({rsp_data, adder_inWord}), 32'd0);
        m_last = 1'b1; m_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        begin
            int seen = 0;
            for (int n = 0; n < 14; n++) begin
                @(negedge clk); #1;
                if (rsp_valid) seen++;
            end
            chk("no_rsp_after_rst", 32'(seen), 32'd0);
        end
        do_job(1'b1, 9'h01F, 1'b1, 9'h0E0, 0, 1'b0);   // ENABLE re-issued

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
